// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch sequencer and its PC / memory / decode neighbours.
// master = fetch unit, slave = surrounding datapath.
interface instr_fetch_unit_if;
  logic [15:0] PC;
  logic        fetch_en;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        ir_ack;
  logic [15:0] MAR;
  logic        mem_rd;
  logic [15:0] IR;
  logic        ir_valid;
  logic        LD_PC;
  logic [1:0]  PCMUX;
  logic        fetch_err;
  logic        busy;

  modport master (
    input  PC, fetch_en, mem_rdata, mem_ready, ir_ack,
    output MAR, mem_rd, IR, ir_valid, LD_PC, PCMUX, fetch_err, busy
  );

  modport slave (
    output PC, fetch_en, mem_rdata, mem_ready, ir_ack,
    input  MAR, mem_rd, IR, ir_valid, LD_PC, PCMUX, fetch_err, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: latches PC into MAR, waits for memory, captures IR, strobes PC+1
// and hands IR to decode over a valid/ack handshake.
//
//  state | meaning
//  IDLE  | no fetch in progress, waiting for fetch_en
//  ADDR  | one cycle, MAR loaded from PC on exit
//  WAIT  | mem_rd asserted, waiting for mem_ready or timeout
//  HOLD  | IR valid, waiting for decode ack
module instr_fetch_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, HOLD} state_t;

  // Wait timer runs down from TIMEOUT-1; terminal count 0 gives TIMEOUT WAIT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      mar, mar_nxt;
  logic [15:0]      ir, ir_nxt;
  logic             ir_valid, ir_valid_nxt;
  logic             fetch_err, fetch_err_nxt;
  logic             mem_rd, ld_pc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mar       <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mar       <= mar_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      fetch_err <= fetch_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mar_nxt       = mar;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    fetch_err_nxt = 1'b0;
    mem_rd        = 1'b0;
    ld_pc         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fetch_en) state_nxt = ADDR;
      end
      ADDR: begin
        mar_nxt   = bus.PC;
        cnt_nxt   = CNT_LOAD;
        state_nxt = WAIT;
      end
      WAIT: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_nxt       = bus.mem_rdata;
          ld_pc        = 1'b1;
          ir_valid_nxt = 1'b1;
          state_nxt    = HOLD;
        end else if (cnt == '0) begin
          fetch_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (bus.ir_ack) begin
          ir_valid_nxt = 1'b0;
          state_nxt    = bus.fetch_en ? ADDR : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.MAR       = mar;
  assign bus.IR        = ir;
  assign bus.ir_valid  = ir_valid;
  assign bus.fetch_err = fetch_err;
  assign bus.mem_rd    = mem_rd;
  assign bus.LD_PC     = ld_pc;
  assign bus.PCMUX     = 2'b00;
  assign bus.busy      = (state != IDLE);

endmodule
